// File: rtl/counter_pkg.sv
// Shared constants for the counter family: count-mode and direction encodings.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// Enabled-cycle prescaler: pulses step on every PRESCALE-th enabled cycle.
// With PRESCALE=1 the counter is pinned at zero, so step simply follows en.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int              CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with <= only, so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign step = en && (cnt == LAST);

endmodule : counter_prescaler

// File: rtl/updown_counter.sv
// Prescaled up/down counter with runtime limit, wrap/saturate and load.
// Optional snapshot register enabled by defining UPDOWN_COUNTER_CAPTURE_EN.
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
`ifdef UPDOWN_COUNTER_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] cap_val,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             at_zero,
  output logic             at_limit
);

  logic             step;
  logic [WIDTH-1:0] step_out;
  logic             step_tc;
  logic [WIDTH-1:0] load_clamped;

  // A load restarts the step period, so it also clears the prescaler.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (en),
    .step  (step)
  );

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    step_out = out;
    step_tc  = 1'b0;
    if (up == DIR_UP) begin
      if (out < limit) begin
        step_out = out + 1'b1;
      end else begin
        step_out = (mode == MODE_SAT) ? limit : '0;
        step_tc  = 1'b1;
      end
    end else begin
      // A lowered limit snaps the count back into range without a pulse.
      if (out > limit) begin
        step_out = limit;
      end else if (out == '0) begin
        step_out = (mode == MODE_SAT) ? '0 : limit;
        step_tc  = 1'b1;
      end else begin
        step_out = out - 1'b1;
      end
    end
  end

  assign load_clamped = (load_val > limit) ? limit : load_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      out <= load_clamped;
      tc  <= 1'b0;
    end else if (step) begin
      out <= step_out;
      tc  <= step_tc;
    end else begin
      tc  <= 1'b0;
    end
  end

`ifdef UPDOWN_COUNTER_CAPTURE_EN
  // Snapshot takes the pre-edge count, independent of same-edge load/step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_val <= '0;
    end else if (capture) begin
      cap_val <= out;
    end
  end
`endif

  assign at_zero  = (out == '0);
  assign at_limit = (out == limit);

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (PRESCALE=1 and PRESCALE=3
// instances sharing one stimulus set).
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic       capture;
  logic [7:0] cap_val;
  logic [7:0] out;
  logic       tc;
  logic       at_zero;
  logic       at_limit;
  logic [7:0] out3;
  logic       tc3;
  logic       at_zero3;
  logic       at_limit3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    .capture  (capture),
    .cap_val  (cap_val),
`endif
    .out      (out),
    .tc       (tc),
    .at_zero  (at_zero),
    .at_limit (at_limit)
  );

  updown_counter #(.WIDTH(8), .PRESCALE(3)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    .capture  (1'b0),
    .cap_val  (),
`endif
    .out      (out3),
    .tc       (tc3),
    .at_zero  (at_zero3),
    .at_limit (at_limit3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_up_out [7] = '{1, 2, 3, 4, 5, 0, 1};
  int exp_up_tc  [7] = '{0, 0, 0, 0, 0, 1, 0};
  int exp_dn_out [4] = '{1, 0, 0, 0};
  int exp_dn_tc  [4] = '{0, 0, 1, 1};
  int exp_ps_out [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    capture  = 1'b0;
    reset    = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    mode     = 1'b0;
    load     = 1'b0;
    load_val = 8'd0;
    limit    = 8'd5;
    tick();
    tick();
    check("reset_out", out, 0);
    check("reset_tc", tc, 0);
    check("reset_at_zero", at_zero, 1);
    check("reset_at_limit", at_limit, 0);

    // Up, wrap, limit 5
    reset = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("up_wrap_out%0d", i), out, exp_up_out[i]);
      check($sformatf("up_wrap_tc%0d", i), tc, exp_up_tc[i]);
      if (i == 4) check("up_wrap_at_limit", at_limit, 1);
    end

    // Down, saturate, load 2 (same-edge step discarded)
    up       = 1'b0;
    mode     = 1'b1;
    load     = 1'b1;
    load_val = 8'd2;
    tick();
    check("dn_sat_load", out, 2);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("dn_sat_out%0d", i), out, exp_dn_out[i]);
      check($sformatf("dn_sat_tc%0d", i), tc, exp_dn_tc[i]);
    end

    // Down, wrap from 0 goes to limit with tc
    mode = 1'b0;
    tick();
    check("dn_wrap_out", out, 5);
    check("dn_wrap_tc", tc, 1);

    // limit 0: count pinned at 0, every step pulses tc
    load     = 1'b1;
    load_val = 8'd0;
    tick();
    load  = 1'b0;
    limit = 8'd0;
    up    = 1'b1;
    tick();
    check("lim0_out", out, 0);
    check("lim0_tc", tc, 1);
    check("lim0_at_limit", at_limit, 1);
    tick();
    check("lim0_tc_again", tc, 1);

    // out=200, limit lowered to 10: up wrap -> 0
    limit    = 8'd255;
    load     = 1'b1;
    load_val = 8'd200;
    tick();
    check("ld200", out, 200);
    load  = 1'b0;
    limit = 8'd10;
    #1;
    check("lowered_at_limit", at_limit, 0);
    tick();
    check("lowered_up_wrap_out", out, 0);
    check("lowered_up_wrap_tc", tc, 1);

    // up saturate -> 10
    limit = 8'd255;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    limit = 8'd10;
    mode  = 1'b1;
    tick();
    check("lowered_up_sat_out", out, 10);
    check("lowered_up_sat_tc", tc, 1);

    // down from above limit -> limit, no tc
    limit = 8'd255;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    limit = 8'd10;
    up    = 1'b0;
    tick();
    check("lowered_dn_out", out, 10);
    check("lowered_dn_tc", tc, 0);

    // Load overflow clamps to limit
    limit    = 8'd20;
    load     = 1'b1;
    load_val = 8'd50;
    up       = 1'b1;
    mode     = 1'b0;
    tick();
    check("load_clamp", out, 20);
    check("load_clamp_tc", tc, 0);
    // Load beats step on the same edge
    load_val = 8'd3;
    tick();
    check("load_wins", out, 3);
    // Reset beats load on the same edge
    reset    = 1'b0;
    load_val = 8'd7;
    tick();
    check("reset_wins", out, 0);
    check("reset_wins_p3", out3, 0);

    // PRESCALE=3: step every third enabled cycle, en gap freezes the phase
    reset = 1'b1;
    load  = 1'b0;
    limit = 8'd255;
    for (int i = 0; i < 9; i++) begin
      en = !(i >= 4 && i < 8);
      tick();
      check($sformatf("ps3_out%0d", i), out3, exp_ps_out[i]);
    end
    en = 1'b1;
    tick();
    check("ps3_resume", out3, 2);
    // Load clears the prescaler phase
    tick();
    load     = 1'b1;
    load_val = 8'd9;
    tick();
    check("ps3_load", out3, 9);
    load = 1'b0;
    tick();
    check("ps3_after_load1", out3, 9);
    tick();
    check("ps3_after_load2", out3, 9);
    tick();
    check("ps3_after_load3", out3, 10);

`ifdef UPDOWN_COUNTER_CAPTURE_EN
    load     = 1'b1;
    load_val = 8'd7;
    tick();
    load    = 1'b0;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    check("cap_val", cap_val, 7);
    check("cap_out", out, 8);
    tick();
    check("cap_hold", cap_val, 7);
    reset = 1'b0;
    tick();
    check("cap_reset", cap_val, 0);
    reset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_updown_counter

// File: doc/updown_counter.md
# updown_counter

Parametrised successor to the team's single-direction free-running counter. Counts up or down at a prescaled rate between 0 and a runtime limit, with wrap or saturate mode, synchronous load and a terminal-count pulse. Used as the general event/timebase counter in the icarus example designs and in small control blocks that need a programmable period.

## Interface
- `WIDTH`, 8: counter width in bits (≥2).
- `PRESCALE`, 1: number of enabled cycles per count step (≥1); 1 means a step on every enabled cycle.

- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `en`  in  1  count enable; feeds the prescaler.
- `up`  in  1  direction: 1 up, 0 down; sampled on each step.
- `mode`  in  1  0 wrap, 1 saturate.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value to load.
- `limit`  in  WIDTH  upper bound of count range, inclusive; may change at any time.
- `out`  out  WIDTH  current count.
- `tc`  out  1  terminal-count pulse, registered.
- `at_zero`  out  1  `out == 0`, combinational from `out`.
- `at_limit`  out  1  `out == limit`, combinational.
- `capture`  in  1  snapshot strobe (only with `UPDOWN_COUNTER_CAPTURE_EN`).
- `cap_val`  out  WIDTH  last captured count (only with `UPDOWN_COUNTER_CAPTURE_EN`).

## Operation
- Priority per edge: reset > load > step > hold.
- Reset (`reset`=0): `out`=0, `tc`=0, prescaler=0, `cap_val`=0.
- Load: `out` <= `load_val` if `load_val` ≤ `limit`, else `limit`; prescaler cleared; `tc`=0; pending step discarded.
- Prescaler: counts enabled cycles 0..PRESCALE-1; `step` asserted on the enabled cycle where it equals PRESCALE-1, then returns to 0. `en`=0 freezes it. PRESCALE=1: `step` = `en`.
- Up step: `out` < `limit` → `out`+1. `out` ≥ `limit` → wrap: 0; saturate: `limit`. `tc` set.
- Down step: 0 < `out` ≤ `limit` → `out`-1. `out` = 0 → wrap: `limit`; saturate: 0; `tc` set. `out` > `limit` (limit lowered) → `limit`, no `tc`.
- `tc` is high exactly for the cycle after a boundary step; cleared on every other edge. Saturated holds with continued steps re-pulse `tc` each step.
- `limit`=0: `out` stays 0; every step pulses `tc`.
- Arithmetic is modulo 2^WIDTH internally but never exceeds `limit` after a step; no carry out.

## Timing
- Step-to-`out` latency: 1 edge. `tc` coincides with the new `out` value.
- `at_zero`/`at_limit` valid same cycle as `out` (and as `limit` changes).
- Load takes effect at the edge where `load`=1; count resumes PRESCALE enabled cycles later.
- `up`, `mode`, `limit` changes apply from the next step; no glitch on `out`.
- Reset mid-count: all state cleared on that edge regardless of `load`/`en`.

## Configuration
- `UPDOWN_COUNTER_CAPTURE_EN` defined: `capture` and `cap_val` ports exist; on an edge with `capture`=1, `cap_val` <= pre-edge `out` (value before any same-edge load/step); `cap_val` holds otherwise; cleared by reset.
- Not defined: ports absent, no capture register; remaining behaviour identical.

## Structure
- Package `counter_pkg`: mode constants `MODE_WRAP`=0, `MODE_SAT`=1; direction constants `DIR_DOWN`=0, `DIR_UP`=1.
- Sub-module `counter_prescaler` (parameter `PRESCALE`; ports `clk`, `reset`, `clr`, `en`, `step`), instantiated once; width `$clog2(PRESCALE)` with PRESCALE=1 degenerating to `step = en`.

## Test plan
- WIDTH=8, PRESCALE=1, limit=5, up, wrap, en=1 from reset: `out` 0,1,2,3,4,5,0; `tc` high only on the cycle `out` returns to 0.
- Down, saturate, limit=5, load 2: `out` 2,1,0,0,0; `tc` high on each cycle `out` holds at 0 after a step.
- PRESCALE=3, limit=255, up: `out` increments every 3rd enabled cycle; drop `en` for 4 cycles mid-period, period resumes where it stopped.
- `out`=200, then limit changed to 10: next up step → 0 (wrap) / 10 (saturate); next down step → 10, `tc`=0.
- Load 300-style overflow: limit=20, load_val=50 → `out`=20; load and step same edge → load wins; reset low same edge as load → `out`=0.
- With `UPDOWN_COUNTER_CAPTURE_EN`: capture at `out`=7 while stepping → `cap_val`=7, `out`=8 next cycle; reset clears `cap_val` to 0.
